// File: rtl/board_status_ctrl.sv
// Board status/indicator controller: sticky run/pass/fail FSM, PWM-dimmed RGB, LEDs, heartbeat, GPIO, buttons.
// Latency: state_o/heartbeat_o/gpio_o 1 cycle; led_o/rgb_*_o 1 cycle after state_o; buttons 2 sync + DEBOUNCE_CYCLES.
// Backpressure: none; every input is sampled every cycle and no request is ever stalled.
// Ports: tests_passed_i/tests_failed_i/clear_i drive state_o; led_o = {heartbeat, failed, passed, run active};
//        brightness_i sets RGB duty; gpio_we_i/gpio_wdata_i/gpio_wmask_i update gpio_o;
//        btn_i -> btn_level_o (debounced) and btn_rise_o.
module board_status_ctrl #(
    parameter int CLK_HZ          = 5_000_000,
    parameter int BLINK_HZ        = 1,
    parameter int N_RGB           = 4,
    parameter int PWM_BITS        = 8,
    parameter int GPIO_W          = 8,
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 50_000
) (
    input  logic                clk_5mhz,
    input  logic                rst_ni,
    input  logic                tests_passed_i,
    input  logic                tests_failed_i,
    input  logic                clear_i,
    input  logic [PWM_BITS-1:0] brightness_i,
    input  logic                gpio_we_i,
    input  logic [GPIO_W-1:0]   gpio_wdata_i,
    input  logic [GPIO_W-1:0]   gpio_wmask_i,
    output logic [GPIO_W-1:0]   gpio_o,
    input  logic [N_BTN-1:0]    btn_i,
    output logic [N_BTN-1:0]    btn_level_o,
    output logic [N_BTN-1:0]    btn_rise_o,
    output logic [1:0]          state_o,
    output logic                heartbeat_o,
    output logic [3:0]          led_o,
    output logic [N_RGB-1:0]    rgb_r_o,
    output logic [N_RGB-1:0]    rgb_g_o,
    output logic [N_RGB-1:0]    rgb_b_o
);

    localparam int HB_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int HB_W    = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_HALF - 1);
    // One spare bit so DEBOUNCE_CYCLES == 1 still yields a legal width.
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PASSED  = 2'd2,
        ST_FAILED  = 2'd3
    } state_e;

    state_e              state_q;
    logic [HB_W-1:0]     hb_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] bright_q;
    logic                pwm_on;
    logic [N_BTN-1:0]    btn_s1;
    logic [N_BTN-1:0]    btn_s2;
    logic [DB_W-1:0]     db_cnt [N_BTN];

    assign state_o = state_q;
    assign pwm_on  = (pwm_cnt < bright_q);

    // Status FSM; FAILED outranks PASSED so a simultaneous pass/fail reports failure.
    always_ff @(posedge clk_5mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else if (clear_i) begin
            state_q <= ST_RUNNING;
        end else begin
            unique case (state_q)
                ST_IDLE:    state_q <= ST_RUNNING;
                ST_RUNNING: begin
                    if (tests_failed_i)      state_q <= ST_FAILED;
                    else if (tests_passed_i) state_q <= ST_PASSED;
                end
                ST_PASSED:  if (tests_failed_i) state_q <= ST_FAILED;
                ST_FAILED:  state_q <= ST_FAILED;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // Heartbeat square wave.
    always_ff @(posedge clk_5mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            hb_cnt      <= '0;
            heartbeat_o <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt      <= '0;
            heartbeat_o <= ~heartbeat_o;
        end else begin
            hb_cnt      <= hb_cnt + 1'b1;
        end
    end

    // PWM: brightness only reloads at the period boundary so a duty change never
    // produces a truncated or stretched pulse.
    always_ff @(posedge clk_5mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_cnt  <= '0;
            bright_q <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (&pwm_cnt) begin
                bright_q <= brightness_i;
            end
        end
    end

    // Indicators follow the registered state, hence one cycle behind state_o.
    // led_o[0] marks an active test run (any state past IDLE).
    always_ff @(posedge clk_5mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            led_o   <= '0;
            rgb_r_o <= '0;
            rgb_g_o <= '0;
            rgb_b_o <= '0;
        end else begin
            led_o   <= {heartbeat_o, state_q == ST_FAILED, state_q == ST_PASSED, state_q != ST_IDLE};
            rgb_r_o <= {N_RGB{(state_q == ST_FAILED) && pwm_on}};
            rgb_g_o <= {N_RGB{(state_q == ST_RUNNING) && pwm_on && heartbeat_o}};
            rgb_b_o <= {N_RGB{(state_q == ST_PASSED) && pwm_on}};
        end
    end

    // GPIO masked write.
    always_ff @(posedge clk_5mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            gpio_o <= '0;
        end else if (gpio_we_i) begin
            gpio_o <= (gpio_o & ~gpio_wmask_i) | (gpio_wdata_i & gpio_wmask_i);
        end
    end

    // Buttons: synchronise, then accept a new level only after it has differed
    // from the current level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk_5mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_s1      <= '0;
            btn_s2      <= '0;
            btn_level_o <= '0;
            btn_rise_o  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            btn_s1 <= btn_i;
            btn_s2 <= btn_s1;
            for (int i = 0; i < N_BTN; i++) begin
                btn_rise_o[i] <= 1'b0;
                if (btn_s2[i] == btn_level_o[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]      <= '0;
                    btn_level_o[i] <= btn_s2[i];
                    btn_rise_o[i]  <= btn_s2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_status_ctrl.sv
// Bench for board_status_ctrl: directed steps followed by randomized traffic,
// every cycle compared against a cycle-count based reference model.
// Model state is kept as plain integers (edges since reset, consecutive-cycle run lengths).
module tb_board_status_ctrl;

    localparam int CLK_HZ   = 1000;
    localparam int BLINK_HZ = 100;
    localparam int HB_HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int N_RGB    = 4;
    localparam int PWM_BITS = 4;
    localparam int PWM_PER  = 1 << PWM_BITS;
    localparam int GPIO_W   = 8;
    localparam int N_BTN    = 4;
    localparam int DEB      = 4;

    logic                clk;
    logic                rst_ni;
    logic                tests_passed_i;
    logic                tests_failed_i;
    logic                clear_i;
    logic [PWM_BITS-1:0] brightness_i;
    logic                gpio_we_i;
    logic [GPIO_W-1:0]   gpio_wdata_i;
    logic [GPIO_W-1:0]   gpio_wmask_i;
    logic [GPIO_W-1:0]   gpio_o;
    logic [N_BTN-1:0]    btn_i;
    logic [N_BTN-1:0]    btn_level_o;
    logic [N_BTN-1:0]    btn_rise_o;
    logic [1:0]          state_o;
    logic                heartbeat_o;
    logic [3:0]          led_o;
    logic [N_RGB-1:0]    rgb_r_o;
    logic [N_RGB-1:0]    rgb_g_o;
    logic [N_RGB-1:0]    rgb_b_o;

    board_status_ctrl #(
        .CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .N_RGB(N_RGB), .PWM_BITS(PWM_BITS),
        .GPIO_W(GPIO_W), .N_BTN(N_BTN), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_5mhz(clk), .rst_ni(rst_ni),
        .tests_passed_i(tests_passed_i), .tests_failed_i(tests_failed_i), .clear_i(clear_i),
        .brightness_i(brightness_i),
        .gpio_we_i(gpio_we_i), .gpio_wdata_i(gpio_wdata_i), .gpio_wmask_i(gpio_wmask_i), .gpio_o(gpio_o),
        .btn_i(btn_i), .btn_level_o(btn_level_o), .btn_rise_o(btn_rise_o),
        .state_o(state_o), .heartbeat_o(heartbeat_o), .led_o(led_o),
        .rgb_r_o(rgb_r_o), .rgb_g_o(rgb_g_o), .rgb_b_o(rgb_b_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model.
    int                cyc;      // rising edges since reset release
    int                m_state;  // 0 idle, 1 running, 2 passed, 3 failed
    int                m_bright;
    logic [GPIO_W-1:0] m_gpio;
    logic [N_BTN-1:0]  m_s1, m_s2, m_lvl, m_rise;
    int                m_run [N_BTN];
    logic [3:0]        e_led;
    logic [N_RGB-1:0]  e_r, e_g, e_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_state = 0; m_bright = 0; m_gpio = '0;
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0;
        for (int i = 0; i < N_BTN; i++) m_run[i] = 0;
        e_led = '0; e_r = '0; e_g = '0; e_b = '0;
    endtask

    task automatic check_all();
        chk("state", 32'(state_o), 32'(m_state));
        chk("heartbeat", 32'(heartbeat_o), 32'((cyc / HB_HALF) % 2));
        chk("led", 32'(led_o), 32'(e_led));
        chk("rgb_r", 32'(rgb_r_o), 32'(e_r));
        chk("rgb_g", 32'(rgb_g_o), 32'(e_g));
        chk("rgb_b", 32'(rgb_b_o), 32'(e_b));
        chk("gpio", 32'(gpio_o), 32'(m_gpio));
        chk("btn_level", 32'(btn_level_o), 32'(m_lvl));
        chk("btn_rise", 32'(btn_rise_o), 32'(m_rise));
    endtask

    // One rising edge: inputs are stable across it, so the model reads them afterwards.
    task automatic step();
        int  pcnt;
        int  phb;
        bit  on;
        @(posedge clk);
        #1;
        pcnt = cyc % PWM_PER;
        phb  = (cyc / HB_HALF) % 2;
        on   = pcnt < m_bright;
        e_led = {phb[0], m_state == 3, m_state == 2, m_state != 0};
        e_r   = (m_state == 3 && on) ? '1 : '0;
        e_g   = (m_state == 1 && on && phb == 1) ? '1 : '0;
        e_b   = (m_state == 2 && on) ? '1 : '0;
        if (pcnt == PWM_PER - 1) m_bright = int'(brightness_i);
        if (clear_i)                          m_state = 1;
        else if (m_state == 0)                m_state = 1;
        else if (m_state == 3)                m_state = 3;
        else if (tests_failed_i)              m_state = 3;
        else if (m_state == 1 && tests_passed_i) m_state = 2;
        if (gpio_we_i) m_gpio = (m_gpio & ~gpio_wmask_i) | (gpio_wdata_i & gpio_wmask_i);
        for (int i = 0; i < N_BTN; i++) begin
            m_rise[i] = 1'b0;
            if (m_s2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_lvl[i]  = m_s2[i];
                    m_rise[i] = m_s2[i];
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = btn_i;
        cyc++;
        check_all();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, 32'(state_o), 32'd0);
        chk({tag, "_hb"}, 32'(heartbeat_o), 32'd0);
        chk({tag, "_led"}, 32'(led_o), 32'd0);
        chk({tag, "_rgb"}, 32'({rgb_r_o, rgb_g_o, rgb_b_o}), 32'd0);
        chk({tag, "_gpio"}, 32'(gpio_o), 32'd0);
        chk({tag, "_btn"}, 32'({btn_level_o, btn_rise_o}), 32'd0);
    endtask

    initial begin
        int cnt_b, cnt_rg, cnt_rise;
        checks = 0; failures = 0;
        rst_ni = 1'b0;
        tests_passed_i = 0; tests_failed_i = 0; clear_i = 0;
        brightness_i = '0; gpio_we_i = 0; gpio_wdata_i = '0; gpio_wmask_i = '0; btn_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_reset_values("reset");

        // Release away from the edge; first edge moves IDLE -> RUNNING.
        @(negedge clk);
        rst_ni = 1'b1;
        step();
        chk("t1_running", 32'(state_o), 32'd1);
        repeat (12) step();
        chk("t1_led0", 32'(led_o[0]), 32'd1);

        // Pass then fail.
        tests_passed_i = 1; step(); tests_passed_i = 0;
        chk("t2_passed", 32'(state_o), 32'd2);
        step();
        chk("t2_led", 32'(led_o[2:0]), 32'b011);
        tests_failed_i = 1; step(); tests_failed_i = 0;
        chk("t2_failed", 32'(state_o), 32'd3);
        step();
        chk("t2_led2", 32'(led_o[2]), 32'd1);
        tests_passed_i = 1; repeat (3) step(); tests_passed_i = 0;
        chk("t2_sticky", 32'(state_o), 32'd3);

        // Clear beats fail; simultaneous pass/fail -> FAILED.
        clear_i = 1; tests_failed_i = 1; step(); clear_i = 0; tests_failed_i = 0;
        chk("t3_clear", 32'(state_o), 32'd1);
        tests_passed_i = 1; tests_failed_i = 1; step(); tests_passed_i = 0; tests_failed_i = 0;
        chk("t3_both", 32'(state_o), 32'd3);
        clear_i = 1; step(); clear_i = 0;
        tests_passed_i = 1; step(); tests_passed_i = 0;

        // PWM duty in PASSED.
        brightness_i = 4'd4;
        repeat (2 * PWM_PER) step();
        cnt_b = 0; cnt_rg = 0;
        for (int i = 0; i < PWM_PER; i++) begin
            step();
            if (rgb_b_o[0]) cnt_b++;
            if (rgb_r_o != 0 || rgb_g_o != 0) cnt_rg++;
        end
        chk("t4_duty", 32'(cnt_b), 32'd4);
        chk("t4_other", 32'(cnt_rg), 32'd0);
        repeat (5) step();
        brightness_i = 4'd0;
        repeat (2 * PWM_PER) step();
        chk("t4_off", 32'(rgb_b_o), 32'd0);

        // GPIO masked writes.
        gpio_we_i = 1; gpio_wdata_i = 8'hFF; gpio_wmask_i = 8'hFF; step();
        chk("t5_ff", 32'(gpio_o), 32'hFF);
        gpio_wdata_i = 8'h00; gpio_wmask_i = 8'h0F; step();
        gpio_we_i = 0;
        chk("t5_f0", 32'(gpio_o), 32'hF0);
        gpio_wdata_i = 8'h00; gpio_wmask_i = 8'hFF; repeat (2) step();
        chk("t5_hold", 32'(gpio_o), 32'hF0);

        // Buttons: short glitch ignored, steady press accepted once.
        btn_i[0] = 1; repeat (DEB - 1) step(); btn_i[0] = 0;
        repeat (8) step();
        chk("t6_glitch", 32'(btn_level_o[0]), 32'd0);
        btn_i[0] = 1;
        repeat (2 + DEB - 1) step();
        chk("t6_not_yet", 32'(btn_level_o[0]), 32'd0);
        step();
        chk("t6_level", 32'(btn_level_o[0]), 32'd1);
        chk("t6_rise", 32'(btn_rise_o[0]), 32'd1);
        cnt_rise = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (btn_rise_o[0]) cnt_rise++;
        end
        chk("t6_rise_once", 32'(cnt_rise), 32'd0);
        btn_i[0] = 0; repeat (10) step();

        // Randomized traffic.
        for (int n = 0; n < 700; n++) begin
            tests_passed_i = ($urandom_range(0, 19) == 0);
            tests_failed_i = ($urandom_range(0, 29) == 0);
            clear_i        = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 29) == 0) brightness_i = PWM_BITS'($urandom);
            gpio_we_i    = ($urandom_range(0, 3) == 0);
            gpio_wdata_i = GPIO_W'($urandom);
            gpio_wmask_i = GPIO_W'($urandom);
            for (int b = 0; b < N_BTN; b++)
                if ($urandom_range(0, 7) == 0) btn_i[b] = ~btn_i[b];
            step();
        end

        // Asynchronous reset mid-operation.
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        check_reset_values("async_rst");
        tests_passed_i = 0; tests_failed_i = 0; clear_i = 0; gpio_we_i = 0;
        @(negedge clk);
        rst_ni = 1'b1;
        model_reset();
        for (int n = 0; n < 60; n++) begin
            btn_i = N_BTN'($urandom);
            brightness_i = PWM_BITS'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
